exc_detect: RTL

EXC_DETECT -- requirements
Module: exc_detect

---
 rtl/exc_detect.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exc_detect.sv
// rtl/exc_detect.sv - MEM-stage exception detector with interrupt synchronizer and IDLE/WAIT/COMMIT commit FSM.
// Holds a detected exception through memory stalls and pulses cp0_en_o/flush_o for exactly one cycle.
module exc_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_ov,
  input  logic        exc_eret,
  input  logic [31:0] mem_addr,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic [5:0]  hw_int,
  input  logic        timer_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        stall_i,
  output logic [31:0] except_type_o,
  output logic        cp0_en_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] cur_pc_o,
  output logic        in_delayslot_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_COMMIT = 2'd2} state_t;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [31:0] T_NONE  = 32'h0;
  localparam logic [31:0] T_INT   = 32'h1;
  localparam logic [31:0] T_ADEL  = 32'h4;
  localparam logic [31:0] T_ADES  = 32'h5;
  localparam logic [31:0] T_SYS   = 32'h8;
  localparam logic [31:0] T_BP    = 32'h9;
  localparam logic [31:0] T_RI    = 32'hA;
  localparam logic [31:0] T_OV    = 32'hC;
  localparam logic [31:0] T_ERET  = 32'hE;

  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0] lat_type_q, lat_type_d, lat_pc_q, lat_pc_d;
  logic [31:0] lat_badv_q, lat_badv_d, lat_tgt_q, lat_tgt_d;
  logic        lat_ds_q, lat_ds_d;
  logic        cp0_en_q, cp0_en_d;
  logic [31:0] type_o_q, type_o_d, new_pc_o_q, new_pc_o_d;
  logic [31:0] badv_o_q, badv_o_d, cur_pc_o_q, cur_pc_o_d;
  logic        ds_o_q, ds_o_d;

  logic [5:0]  sync_hw;
  logic        int_pend, fetch_err, data_mis;
  logic [31:0] det_type, det_badv;
  logic        unused_bits;

  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10], cp0_cause[7:0]};

  always_comb begin
    sync1_d   = hw_int;
    sync2_d   = sync1_q;
    sync_hw   = sync2_q | {timer_int, 5'b0};
    int_pend  = (|({sync_hw, cp0_cause[9:8]} & cp0_status[15:8])) && cp0_status[0] && !cp0_status[1];
    fetch_err = mem_pc[1:0] != 2'b00;
    data_mis  = (mem_size == 2'b01 && mem_addr[0]) || (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

    det_badv = mem_addr;
    if (int_pend)                    det_type = T_INT;
    else if (fetch_err) begin        det_type = T_ADEL; det_badv = mem_pc; end
    else if (exc_ri)                 det_type = T_RI;
    else if (exc_ov)                 det_type = T_OV;
    else if (exc_sys)                det_type = T_SYS;
    else if (exc_bp)                 det_type = T_BP;
    else if (exc_eret)               det_type = T_ERET;
    else if (data_mis && mem_ren)    det_type = T_ADEL;
    else if (data_mis && mem_wen)    det_type = T_ADES;
    else                             det_type = T_NONE;

    state_d    = state_q;
    lat_type_d = lat_type_q;
    lat_pc_d   = lat_pc_q;
    lat_ds_d   = lat_ds_q;
    lat_badv_d = lat_badv_q;
    lat_tgt_d  = lat_tgt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid && det_type != T_NONE) begin
          lat_type_d = det_type;
          lat_pc_d   = mem_pc;
          lat_ds_d   = mem_in_delayslot;
          lat_badv_d = det_badv;
          lat_tgt_d  = (det_type == T_ERET) ? cp0_epc : EXC_VEC;
          state_d    = stall_i ? S_WAIT : S_COMMIT;
        end
      end
      S_WAIT:  if (!stall_i) state_d = S_COMMIT;
      default: state_d = S_IDLE;
    endcase

    // Outputs load on the edge entering COMMIT so they are registered for the pulse cycle.
    cp0_en_d   = (state_d == S_COMMIT);
    type_o_d   = cp0_en_d ? lat_type_d : T_NONE;
    new_pc_o_d = new_pc_o_q;
    badv_o_d   = badv_o_q;
    cur_pc_o_d = cur_pc_o_q;
    ds_o_d     = ds_o_q;
    if (cp0_en_d) begin
      new_pc_o_d = lat_tgt_d;
      cur_pc_o_d = lat_pc_d;
      ds_o_d     = lat_ds_d;
      if (lat_type_d == T_ADEL || lat_type_d == T_ADES) badv_o_d = lat_badv_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      lat_type_q <= '0;
      lat_pc_q   <= '0;
      lat_ds_q   <= 1'b0;
      lat_badv_q <= '0;
      lat_tgt_q  <= '0;
      cp0_en_q   <= 1'b0;
      type_o_q   <= '0;
      new_pc_o_q <= '0;
      badv_o_q   <= '0;
      cur_pc_o_q <= '0;
      ds_o_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lat_type_q <= lat_type_d;
      lat_pc_q   <= lat_pc_d;
      lat_ds_q   <= lat_ds_d;
      lat_badv_q <= lat_badv_d;
      lat_tgt_q  <= lat_tgt_d;
      cp0_en_q   <= cp0_en_d;
      type_o_q   <= type_o_d;
      new_pc_o_q <= new_pc_o_d;
      badv_o_q   <= badv_o_d;
      cur_pc_o_q <= cur_pc_o_d;
      ds_o_q     <= ds_o_d;
    end
  end

  assign except_type_o  = type_o_q;
  assign cp0_en_o       = cp0_en_q;
  assign flush_o        = cp0_en_q;
  assign new_pc_o       = new_pc_o_q;
  assign badvaddr_o     = badv_o_q;
  assign cur_pc_o       = cur_pc_o_q;
  assign in_delayslot_o = ds_o_q;

endmodule
